// File: rtl/rst_seq_if.sv
// Request/status bundle between a reset sequencer and whatever drives its software reset.
// The sequencer drives the status side; the requester drives the request side.
interface rst_seq_if #(
  parameter int N_CH = 4
);
  // sw_rst_req is a level, not a valid/ready handshake. It is acted on at a clk edge
  // only when the sequencer is in RUN and sw_rst_mask is nonzero. Otherwise it is dropped.
  // It is never queued. ready/busy report whether the sequencer is back in RUN.
  logic            sw_rst_req;
  logic [N_CH-1:0] sw_rst_mask;
  logic [N_CH-1:0] srst;
  logic [N_CH-1:0] srstn;
  logic            ready;
  logic            busy;
  logic [7:0]      sw_rst_cnt;

  modport master (
    output sw_rst_req, sw_rst_mask,
    input  srst, srstn, ready, busy, sw_rst_cnt
  );

  modport slave (
    input  sw_rst_req, sw_rst_mask,
    output srst, srstn, ready, busy, sw_rst_cnt
  );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: board reset -> N_CH synchronous resets with minimum pulse width and staggered release.
// Optional macro RST_SEQ_SWCNT_EN builds the saturating completed-software-reset counter.
module rst_seq #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 16,
  parameter int STAGGER     = 8
) (
  input  logic       clk,
  input  logic       arst,
  rst_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int CW        = $clog2(MIN_PULSE + (N_CH - 1) * STAGGER + 1);
  localparam int LAST_SLOT = (N_CH - 1) * STAGGER;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_CH-1:0]        srst_q, srst_d;
  logic [N_CH-1:0]        srstn_q;
  logic                   ready_q, busy_q;
  logic                   release_now;
  logic [CW-1:0]          slot;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      sync_q  <= '1;
      srst_q  <= '1;
      srstn_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      srst_q  <= srst_d;
      srstn_q <= ~srst_d;
      ready_q <= (state_d == RUN);
      busy_q  <= (state_d != RUN);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b0};
    srst_d      = srst_q;
    release_now = 1'b0;
    slot        = '0;
    case (state_q)
      SYNC: begin
        cnt_d = '0;
        // Last stage still high with a 0 behind it: it drops on this edge.
        if (sync_q[SYNC_STAGES-1 -: 2] == 2'b10) state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == CW'(MIN_PULSE - 1)) begin
          // This edge is release slot 0. The counter then names the next edge's slot.
          release_now = 1'b1;
          slot        = '0;
          cnt_d       = CW'(1);
          state_d     = (LAST_SLOT == 0) ? RUN : RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        release_now = 1'b1;
        slot        = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CW'(LAST_SLOT)) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (bus.sw_rst_req && (bus.sw_rst_mask != '0)) begin
          srst_d  = srst_q | bus.sw_rst_mask;
          state_d = HOLD;
        end
      end
      default: state_d = SYNC;
    endcase
    // Channels outside the active set are already 0, so clearing them again is harmless.
    for (int i = 0; i < N_CH; i++) begin
      if (release_now && (slot == CW'(i * STAGGER))) srst_d[i] = 1'b0;
    end
  end

`ifdef RST_SEQ_SWCNT_EN
  logic       sw_pend_q;
  logic [7:0] swcnt_q;

  // RUN->HOLD happens only for a software reset. ARST clears the pending flag, so an aborted reset is never counted.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sw_pend_q <= 1'b0;
      swcnt_q   <= '0;
    end else if (state_q == RUN && state_d == HOLD) begin
      sw_pend_q <= 1'b1;
    end else if (sw_pend_q && state_q != RUN && state_d == RUN) begin
      sw_pend_q <= 1'b0;
      if (swcnt_q != 8'hFF) swcnt_q <= swcnt_q + 8'd1;
    end
  end

  assign bus.sw_rst_cnt = swcnt_q;
`else
  assign bus.sw_rst_cnt = '0;
`endif

  assign bus.srst  = srst_q;
  assign bus.srstn = srstn_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign dbg_state = state_q;

endmodule
